// File: rtl/pedal_pkg.sv
//============================================================================
// Module      : pedal_pkg
// Description : Shared types and helpers for the effects-chain FIR sequencer.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

package pedal_pkg;

   localparam int SAMPLE_W = 24;

   typedef logic signed [SAMPLE_W-1:0] sample_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MAC   = 2'd1,
      ROUND = 2'd2,
      OUT   = 2'd3
   } fir_state_e;

   // Wide enough that TAPS full-precision products can never overflow.
   function automatic int acc_width(input int width, input int taps);
      return 2 * width + $clog2(taps);
   endfunction

endpackage

`default_nettype wire

// File: rtl/fir_mac_sequencer_round_sat.sv
//============================================================================
// Module      : round_sat
// Description : Round-half-up, arithmetic shift by COEF_FRAC, saturate to WIDTH.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module round_sat #(
   parameter int ACC_W     = 51,
   parameter int WIDTH     = 24,
   parameter int COEF_FRAC = 23
) (
   input  logic signed [ACC_W-1:0] acc,
   output logic signed [WIDTH-1:0] sat
);

   // One guard bit so the rounding offset can never wrap the sum.
   localparam int EXT_W = ACC_W + 1;
   localparam logic signed [EXT_W-1:0] HALF    = EXT_W'(1) <<< (COEF_FRAC - 1);
   localparam logic signed [EXT_W-1:0] SAT_MAX = {{(EXT_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
   localparam logic signed [EXT_W-1:0] SAT_MIN = {{(EXT_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

   logic signed [EXT_W-1:0] biased;
   logic signed [EXT_W-1:0] shifted;

   always_comb begin
      biased  = EXT_W'(acc) + HALF;
      shifted = biased >>> COEF_FRAC;
      if (shifted > SAT_MAX) begin
         sat = SAT_MAX[WIDTH-1:0];
      end else if (shifted < SAT_MIN) begin
         sat = SAT_MIN[WIDTH-1:0];
      end else begin
         sat = shifted[WIDTH-1:0];
      end
   end

endmodule

`default_nettype wire

// File: rtl/fir_mac_sequencer.sv
//============================================================================
// Module      : fir_mac_sequencer
// Description : Time-multiplexed FIR; one shared MAC walks all taps per sample.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module fir_mac_sequencer
   import pedal_pkg::*;
#(
   parameter int WIDTH     = 24,
   parameter int TAPS      = 8,
   parameter int COEF_FRAC = 23
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     s_valid,
   output logic                     s_ready,
   input  logic [WIDTH-1:0]         s_data,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic [WIDTH-1:0]         m_data,
   input  logic                     cfg_we,
   input  logic [$clog2(TAPS)-1:0]  cfg_addr,
   input  logic [WIDTH-1:0]         cfg_data,
   output logic                     busy
);

   localparam int              ACC_W  = acc_width(WIDTH, TAPS);
   localparam int              K_W    = $clog2(TAPS);
   localparam logic [K_W-1:0]  K_LAST = K_W'(TAPS - 1);

   fir_state_e               state_q, state_d;
   logic [K_W-1:0]           k_q, k_d;
   logic signed [ACC_W-1:0]  acc_q, acc_d;
   logic signed [WIDTH-1:0]  hist_q   [TAPS];
   logic signed [WIDTH-1:0]  hist_d   [TAPS];
   logic signed [WIDTH-1:0]  shadow_q [TAPS];
   logic signed [WIDTH-1:0]  shadow_d [TAPS];
   logic signed [WIDTH-1:0]  active_q [TAPS];
   logic signed [WIDTH-1:0]  active_d [TAPS];
   logic [WIDTH-1:0]         m_data_q, m_data_d;

   logic                     accept;
   logic signed [2*WIDTH-1:0] product;
   logic signed [WIDTH-1:0]  rounded;

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept)        state_d = MAC;
         MAC:     if (k_q == K_LAST) state_d = ROUND;
         ROUND:                      state_d = OUT;
         OUT:     if (m_ready)       state_d = IDLE;
         default:                    state_d = IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      s_ready = (state_q == IDLE);
      m_valid = (state_q == OUT);
      busy    = (state_q != IDLE);
   end

   assign accept  = s_valid && s_ready;
   assign product = hist_q[k_q] * active_q[k_q];
   assign m_data  = m_data_q;

   round_sat #(
      .ACC_W     (ACC_W),
      .WIDTH     (WIDTH),
      .COEF_FRAC (COEF_FRAC)
   ) u_round_sat (
      .acc (acc_q),
      .sat (rounded)
   );

   always_comb begin
      k_d      = k_q;
      acc_d    = acc_q;
      m_data_d = m_data_q;
      hist_d   = hist_q;
      shadow_d = shadow_q;
      active_d = active_q;

      if (accept) begin
         hist_d[0] = s_data;
         for (int i = 1; i < TAPS; i++) begin
            hist_d[i] = hist_q[i-1];
         end
         active_d = shadow_q;
         acc_d    = '0;
         k_d      = '0;
      end

      if (state_q == MAC) begin
         acc_d = acc_q + ACC_W'(product);
         k_d   = k_q + K_W'(1);
      end

      if (state_q == ROUND) begin
         m_data_d = rounded;
      end

      // The shadow write lands after the active copy above, so a write in the
      // accept cycle only takes effect for the following sample.
      if (cfg_we && (32'(cfg_addr) < TAPS)) begin
         shadow_d[cfg_addr] = cfg_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         k_q      <= '0;
         acc_q    <= '0;
         m_data_q <= '0;
         for (int i = 0; i < TAPS; i++) begin
            hist_q[i]   <= '0;
            shadow_q[i] <= '0;
            active_q[i] <= '0;
         end
      end else begin
         k_q      <= k_d;
         acc_q    <= acc_d;
         m_data_q <= m_data_d;
         hist_q   <= hist_d;
         shadow_q <= shadow_d;
         active_q <= active_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_fir_mac_sequencer.sv
//============================================================================
// Module      : tb_fir_mac_sequencer
// Description : Scoreboard bench for the time-multiplexed FIR sequencer.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_fir_mac_sequencer;
   import pedal_pkg::*;

   localparam int WIDTH     = 24;
   localparam int TAPS      = 8;
   localparam int COEF_FRAC = 23;
   localparam int AW        = $clog2(TAPS);

   logic              clk      = 1'b0;
   logic              reset    = 1'b1;
   logic              s_valid  = 1'b0;
   logic              m_ready  = 1'b1;
   logic              cfg_we   = 1'b0;
   logic [WIDTH-1:0]  s_data   = '0;
   logic [WIDTH-1:0]  cfg_data = '0;
   logic [AW-1:0]     cfg_addr = '0;
   logic              s_ready;
   logic              m_valid;
   logic              busy;
   logic [WIDTH-1:0]  m_data;

   int total   = 0;
   int bad     = 0;
   int acc_cnt = 0;

   logic [WIDTH-1:0] exp_q [$];
   longint           mh   [TAPS];
   longint           msh  [TAPS];
   longint           mact [TAPS];

   fir_mac_sequencer #(
      .WIDTH     (WIDTH),
      .TAPS      (TAPS),
      .COEF_FRAC (COEF_FRAC)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .s_valid  (s_valid),
      .s_ready  (s_ready),
      .s_data   (s_data),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .m_data   (m_data),
      .cfg_we   (cfg_we),
      .cfg_addr (cfg_addr),
      .cfg_data (cfg_data),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [WIDTH-1:0] model_out();
      longint sum = 0;
      longint r;
      for (int k = 0; k < TAPS; k++) sum += mh[k] * mact[k];
      r = (sum + (64'sd1 <<< (COEF_FRAC - 1))) >>> COEF_FRAC;
      if (r > 64'sd8388607)       r = 64'sd8388607;
      else if (r < -64'sd8388608) r = -64'sd8388608;
      return r[WIDTH-1:0];
   endfunction

   // Reference model and scoreboard, evaluated mid-cycle on stable signals.
   always @(negedge clk) begin
      sample_t v;
      if (reset) begin
         for (int i = 0; i < TAPS; i++) begin
            mh[i] = 0; msh[i] = 0; mact[i] = 0;
         end
         exp_q.delete();
      end else begin
         if (m_valid && m_ready) begin
            if (exp_q.size() == 0) chk("sb_underflow", 64'(exp_q.size()), 64'd1);
            else                   chk("out_data", m_data, exp_q.pop_front());
         end
         if (s_valid && s_ready) begin
            for (int i = TAPS - 1; i > 0; i--) mh[i] = mh[i-1];
            v = s_data;
            mh[0] = longint'(v);
            for (int i = 0; i < TAPS; i++) mact[i] = msh[i];
            exp_q.push_back(model_out());
            acc_cnt++;
         end
         if (cfg_we) begin
            v = cfg_data;
            msh[cfg_addr] = longint'(v);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input string tag);
      reset   = 1'b1;
      s_valid = 1'b0;
      cfg_we  = 1'b0;
      m_ready = 1'b1;
      tick();
      reset = 1'b0;
      chk({tag, "_m_valid"}, 64'(m_valid), 64'd0);
      chk({tag, "_m_data"},  64'(m_data),  64'd0);
      chk({tag, "_s_ready"}, 64'(s_ready), 64'd1);
      chk({tag, "_busy"},    64'(busy),    64'd0);
   endtask

   task automatic write_coef(input int a, input logic [WIDTH-1:0] d);
      cfg_we   = 1'b1;
      cfg_addr = AW'(a);
      cfg_data = d;
      tick();
      cfg_we = 1'b0;
   endtask

   task automatic send(input logic [WIDTH-1:0] x);
      int n = 0;
      s_valid = 1'b1;
      s_data  = x;
      while (!s_ready && n < 200) begin
         tick();
         n++;
      end
      if (!s_ready) chk("send_timeout", 64'(n), 64'd0);
      tick();
      s_valid = 1'b0;
   endtask

   task automatic drain(input string tag);
      int n = 0;
      m_ready = 1'b1;
      while ((exp_q.size() != 0 || busy) && n < 100) begin
         tick();
         n++;
      end
      chk({tag, "_drain"}, 64'(n < 100), 64'd1);
   endtask

   initial begin
      int cnt;
      int acc_snap;

      // Single-tap gain and latency
      do_reset("rst0");
      write_coef(0, 24'h400000);
      send(24'h200000);
      cnt = 1;
      while (!m_valid && cnt < 50) begin
         tick();
         cnt++;
      end
      chk("latency", 64'(cnt), 64'd10);
      drain("gain");
      chk("gain_val", 64'(m_data), 64'h100000);

      // Impulse through a ramp of coefficients
      do_reset("rst1");
      for (int k = 0; k < TAPS; k++) write_coef(k, WIDTH'(k * 24'h010000));
      send(24'h7FFFFF);
      for (int k = 1; k < TAPS; k++) send(24'h000000);
      drain("impulse");
      chk("impulse_last", 64'(m_data), 64'h070000);

      // Positive and negative saturation
      do_reset("rst2");
      write_coef(0, 24'h7FFFFF);
      write_coef(1, 24'h7FFFFF);
      send(24'h7FFFFF);
      send(24'h7FFFFF);
      drain("satp");
      chk("sat_pos", 64'(m_data), 64'h7FFFFF);

      do_reset("rst3");
      write_coef(0, 24'h7FFFFF);
      write_coef(1, 24'h7FFFFF);
      send(24'h800000);
      send(24'h800000);
      drain("satn");
      chk("sat_neg", 64'(m_data), 64'h800000);

      // Backpressure: output held, no new sample until after handshake
      do_reset("rst4");
      write_coef(0, 24'h400000);
      m_ready = 1'b0;
      send(24'h200000);
      s_valid = 1'b1;
      s_data  = 24'h100000;
      cnt = 0;
      while (!m_valid && cnt < 50) begin
         tick();
         cnt++;
      end
      chk("bp_reach_out", 64'(m_valid), 64'd1);
      acc_snap = acc_cnt;
      for (int i = 0; i < 5; i++) begin
         chk("bp_data",    64'(m_data),  64'h100000);
         chk("bp_s_ready", 64'(s_ready), 64'd0);
         chk("bp_valid",   64'(m_valid), 64'd1);
         tick();
      end
      chk("bp_no_accept", 64'(acc_cnt), 64'(acc_snap));
      m_ready = 1'b1;
      tick();
      chk("bp_post_valid", 64'(m_valid), 64'd0);
      chk("bp_post_ready", 64'(s_ready), 64'd1);
      chk("bp_post_hold",  64'(m_data),  64'h100000);
      chk("bp_not_yet",    64'(acc_cnt), 64'(acc_snap));
      tick();
      s_valid = 1'b0;
      chk("bp_accept", 64'(acc_cnt), 64'(acc_snap + 1));
      drain("bp");
      chk("bp_second", 64'(m_data), 64'h080000);

      // Coefficient write during MAC applies to the next sample only
      do_reset("rst5");
      write_coef(0, 24'h400000);
      send(24'h200000);
      tick();
      tick();
      write_coef(0, 24'h200000);
      drain("cfgmac1");
      chk("cfgmac_first", 64'(m_data), 64'h100000);
      send(24'h200000);
      drain("cfgmac2");
      chk("cfgmac_second", 64'(m_data), 64'h080000);

      // Reset in the 4th MAC cycle discards the sample and history
      do_reset("rst6");
      write_coef(0, 24'h400000);
      write_coef(1, 24'h400000);
      send(24'h300000);
      tick();
      tick();
      tick();
      do_reset("midmac");
      write_coef(0, 24'h400000);
      send(24'h200000);
      drain("postrst");
      chk("postrst_val", 64'(m_data), 64'h100000);
      chk("sb_leftover", 64'(exp_q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
